// File: rtl/rz_encoder.sv
// WS2812-class RZ encoder: 24-bit colour word sent MSB first as high/low pulses; define RZ_RESET_GAP_EN for a post-frame low gap.
// Latency: RZ_data rises one edge after the done_sig edge; each bit lasts TxH+TxL cycles, a frame 24 bits.
// Backpressure: none; done_sig is dropped while a frame (or gap) is in flight.
module rz_encoder #(
  parameter int T0H     = 20,
  parameter int T0L     = 43,
  parameter int T1H     = 40,
  parameter int T1L     = 23,
  parameter int RES_CYC = 2500
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [23:0] RGB,
  input  logic        done_sig,
  output logic        RZ_data
);

  // Bit timings must fit the 6-bit cycle counter, the gap the 12-bit one.
  if (T0H < 1 || T1H < 1 || T0L < 1 || T1L < 1 || T0H + T0L > 64 || T1H + T1L > 64 ||
      RES_CYC < 1 || RES_CYC > 4096) begin : g_bad_params
    $error("rz_encoder: timing parameters out of counter range");
  end

`ifdef RZ_RESET_GAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, GAP = 2'd2} state_t;
  localparam logic [11:0] GAP_LAST = 12'(RES_CYC - 1);
  logic [11:0] gap_cnt;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1} state_t;
`endif

  localparam logic [5:0] T0H_C    = 6'(T0H);
  localparam logic [5:0] T1H_C    = 6'(T1H);
  localparam logic [5:0] T0_LAST  = 6'(T0H + T0L - 1);
  localparam logic [5:0] T1_LAST  = 6'(T1H + T1L - 1);

  state_t      state, state_nxt;
  logic [23:0] shreg;
  logic [4:0]  bit_idx;
  logic [5:0]  cyc;
  logic [5:0]  hi_len;
  logic        bit_last;
  logic        frame_last;
  logic        rz_nxt;

  always_comb begin
    hi_len     = shreg[23] ? T1H_C : T0H_C;
    bit_last   = (cyc == (shreg[23] ? T1_LAST : T0_LAST));
    frame_last = bit_last && (bit_idx == 5'd23);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state   <= IDLE;
      RZ_data <= 1'b0;
    end else begin
      state   <= state_nxt;
      RZ_data <= rz_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (done_sig) state_nxt = SEND;
`ifdef RZ_RESET_GAP_EN
      SEND: if (frame_last) state_nxt = GAP;
      GAP:  if (gap_cnt == GAP_LAST) state_nxt = IDLE;
`else
      SEND: if (frame_last) state_nxt = IDLE;
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Registered through RZ_data so bit boundaries never glitch.
  always_comb begin
    rz_nxt = (state == SEND) && (cyc < hi_len);
  end

  always_ff @(posedge clk) begin
    if (rst_n) begin
      shreg   <= '0;
      bit_idx <= '0;
      cyc     <= '0;
`ifdef RZ_RESET_GAP_EN
      gap_cnt <= '0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (done_sig) begin
            shreg   <= RGB;
            bit_idx <= '0;
            cyc     <= '0;
          end
        end
        SEND: begin
          if (bit_last) begin
            shreg   <= {shreg[22:0], 1'b0};
            bit_idx <= bit_idx + 5'd1;
            cyc     <= '0;
`ifdef RZ_RESET_GAP_EN
            gap_cnt <= '0;
`endif
          end else begin
            cyc <= cyc + 6'd1;
          end
        end
`ifdef RZ_RESET_GAP_EN
        GAP: gap_cnt <= gap_cnt + 12'd1;
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_rz_encoder.sv
// Randomized bench for rz_encoder: cycle-level waveform model plus a pulse-width decoder.
module tb_rz_encoder;

  localparam int FRAME = 24 * 63;
`ifdef RZ_RESET_GAP_EN
  localparam int GAPC = 2500;
`else
  localparam int GAPC = 0;
`endif

  logic        clk;
  logic        rst;
  logic [23:0] rgb;
  logic        done;
  logic        rz;

  int n_vec = 0;
  int n_err = 0;

  rz_encoder dut (
    .clk      (clk),
    .rst_n    (rst),
    .RGB      (rgb),
    .done_sig (done),
    .RZ_data  (rz)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
    end
  endtask

  // Expected line level n edges after the accepted strobe edge.
  function automatic logic wave(input logic [23:0] v, input int n);
    int b, p, hi;
    logic [23:0] vv;
    if (n < 1 || n > FRAME) return 1'b0;
    vv = v;
    b  = (n - 1) / 63;
    p  = (n - 1) % 63;
    hi = vv[23 - b] ? 40 : 20;
    return p < hi;
  endfunction

  int          cyc_cnt = 0;
  bit          busy = 0;
  int          start = 0;
  logic [23:0] val = '0;
  logic        exp_rz = 1'b0;

  always @(posedge clk) begin
    cyc_cnt++;
    if (rst) begin
      busy   = 0;
      exp_rz = 1'b0;
    end else begin
      if (busy && (cyc_cnt - start > FRAME + GAPC)) busy = 0;
      if (!busy && done) begin
        busy  = 1;
        start = cyc_cnt;
        val   = rgb;
      end
      exp_rz = busy ? wave(val, cyc_cnt - start) : 1'b0;
    end
  end

  always @(negedge clk) begin
    if (cyc_cnt > 0) chk("rz_level", 32'(rz), 32'(exp_rz));
  end

  // Pulse-width decoder: high run 40 -> '1', 20 -> '0'.
  int          hi_run = 0;
  logic [23:0] dec = '0;
  int          nbits = 0;

  always @(negedge clk) begin
    if (rst) begin
      hi_run = 0;
    end else if (rz === 1'b1) begin
      hi_run++;
    end else if (hi_run > 0) begin
      chk("hi_run_len", 32'(hi_run == 20 || hi_run == 40), 32'd1);
      dec    = {dec[22:0], hi_run == 40};
      nbits++;
      hi_run = 0;
    end
  end

  task automatic clr_dec();
    @(posedge clk);
    dec   = '0;
    nbits = 0;
  endtask

  // Strobe v, change RGB to rgb_after next cycle, optional extra strobe, run 'total' cycles.
  task automatic run_frame(input logic [23:0] v, input logic [23:0] rgb_after,
                           input int extra_at, input int total);
    clr_dec();
    @(negedge clk);
    rgb  = v;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    rgb  = rgb_after;
    for (int i = 1; i < total; i++) begin
      if (i == extra_at) begin
        done = 1'b1;
        rgb  = 24'($urandom);
      end else begin
        done = 1'b0;
      end
      @(negedge clk);
    end
    done = 1'b0;
    chk("dec_val", 32'(dec), 32'(v));
    chk("dec_bits", 32'(nbits), 32'd24);
  endtask

  initial begin
    logic [23:0] v1, v2;
    rst  = 1'b1;
    done = 1'b0;
    rgb  = 24'hFFFFFF;

    // Reset with a strobe inside it: nothing may start.
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      done = (i == 2);
      chk("rst_hold_rz", 32'(rz), 32'd0);
    end
    @(negedge clk);
    done = 1'b0;
    rst  = 1'b0;
    repeat (20) @(negedge clk);
    chk("no_frame_after_rst", 32'(rz), 32'd0);
    chk("no_bits_after_rst", 32'(nbits), 32'd0);

    // First frame, RGB changed after strobe, extra strobe at cycle 500; second 100 us later.
    run_frame(24'hB9E40E, 24'hFFFFFF, 500, 5000);
    run_frame(24'h0EB9E4, 24'($urandom), 0, FRAME + GAPC + 20);
    chk("idle_after_frame", 32'(rz), 32'd0);

    // Mid-bit reset at cycle 700, then 0x000001.
    clr_dec();
    @(negedge clk);
    rgb  = 24'h5A5A5A;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    repeat (698) @(negedge clk);
    chk("pre_rst_level", 32'(rz), 32'(wave(24'h5A5A5A, 699)));
    rst = 1'b1;
    @(negedge clk);
    chk("rst_midbit_rz", 32'(rz), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    run_frame(24'h000001, 24'hFFFFFF, 0, FRAME + GAPC + 20);

    // Back-to-back: strobe high at the last busy edge (dropped) and the first idle edge (taken).
    v1 = 24'($urandom);
    v2 = 24'($urandom);
    clr_dec();
    @(negedge clk);
    rgb  = v1;
    done = 1'b1;
    @(negedge clk);
    done = 1'b0;
    for (int i = 1; i < 2 * FRAME + GAPC + 20; i++) begin
      done = (i == FRAME + GAPC) || (i == FRAME + GAPC + 1);
      rgb  = v2;
      @(negedge clk);
    end
    done = 1'b0;
    chk("b2b_dec_val", 32'(dec), 32'(v2));
    chk("b2b_dec_bits", 32'(nbits), 32'd48);

    // Random frames with random stray strobes and spacing.
    for (int k = 0; k < 4; k++) begin
      run_frame(24'($urandom), 24'($urandom), $urandom_range(1, FRAME - 1),
                FRAME + GAPC + $urandom_range(5, 200));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/rz_encoder.md
# rz_encoder

Serial return-to-zero (RZ) line encoder for one WS2812-class LED pixel. A single-cycle start pulse latches a 24-bit colour word, which is shifted out MSB first as timed high/low pulses on one output pin. The block sits between the pixel-data sequencer and the LED data pin, running on the 50 MHz system clock.

## Interface
Parameters:
- T0H, 20: high cycles for a '0' bit (0.40 µs at 50 MHz)
- T0L, 43: low cycles for a '0' bit
- T1H, 40: high cycles for a '1' bit (0.80 µs)
- T1L, 23: low cycles for a '1' bit
- RES_CYC, 2500: latch/reset gap low cycles after a frame (50 µs); used only with RZ_RESET_GAP_EN

Ports:
- clk  in  1  system clock, 50 MHz, all logic on rising edge
- rst_n  in  1  one clock; reset is synchronous and active-high (asserted = 1 despite the suffix)
- RGB  in  24  colour word; bit 23 is sent first
- done_sig  in  1  start strobe, one-cycle pulse
- RZ_data  out  1  encoded serial output, registered

## Operation
- FSM states: IDLE, SEND, GAP (GAP exists only with RZ_RESET_GAP_EN).
- IDLE: RZ_data = 0. When done_sig = 1, latch RGB into a 24-bit shift register, clear the bit index (5 bits) and the cycle counter (6 bits), and go to SEND.
- SEND: the current bit is shreg[23]. RZ_data = 1 while cyc < TxH, otherwise 0. The bit lasts TxH+TxL cycles. At the last cycle, shift left by one, increment the index, and reset cyc.
- After bit index 23 completes, go to GAP if enabled, otherwise go to IDLE.
- GAP: RZ_data = 0 for RES_CYC cycles (12-bit counter), then go to IDLE.
- done_sig is ignored in SEND and GAP. There is no queuing; the strobe is dropped.
- RGB is sampled only in the done_sig cycle. Later changes to RGB do not affect the frame in flight.
- Reset at any time, including mid-bit: state goes to IDLE, RZ_data = 0, and the shift register and all counters are cleared on the next edge.

## Timing
- Reset value: RZ_data = 0, state IDLE.
- Latency: done_sig is high at edge k, and RZ_data rises at edge k+1.
- '1' bit: exactly 40 high plus 23 low cycles. '0' bit: exactly 20 high plus 43 low cycles. Both are 63 cycles (1.26 µs).
- Frame: 24 × 63 = 1512 cycles from the first rising edge to the end of the last low period.
- Without a gap, a new done_sig is accepted on the first IDLE cycle after the frame, i.e. at cycle 1512 after the start edge.
- With a gap, a new done_sig is accepted 1512 + RES_CYC cycles after the start edge.
- If done_sig and rst_n are both asserted in the same cycle, reset wins and nothing is latched.
- Bit boundaries are glitch-free: RZ_data is a flop output with no combinational path from the inputs.

## Configuration
- RZ_RESET_GAP_EN defined: after each frame the FSM enters GAP and holds RZ_data low for RES_CYC cycles, which guarantees the LED latch time. done_sig is ignored during the gap.
- RZ_RESET_GAP_EN undefined: GAP state and its counter are not built. The FSM returns to IDLE directly after bit 23, and the upstream sequencer is responsible for spacing frames at least 50 µs apart.

## Test plan
- Reset held 5 cycles with done_sig pulsed during it -> RZ_data = 0 throughout, no frame starts.
- Reset released, RGB = 0xB9E40E, done_sig pulsed once -> first bits 1,0,1,1: high/low runs of 40/23, 20/43, 40/23, 40/23. Full 24-bit pattern decodes to 0xB9E40E in 1512 cycles, then RZ_data stays 0.
- RGB changed to 0xFFFFFF one cycle after the strobe -> transmitted pattern is still 0xB9E40E.
- Extra done_sig pulse at cycle 500 of a frame -> ignored. The frame is unchanged and no second frame follows.
- Second frame 0x0EB9E4 strobed 100 µs after the first -> decodes as 0x0EB9E4 with the same per-bit timing.
- rst_n asserted mid-bit at cycle 700 -> RZ_data = 0 on the next edge. A done_sig with RGB = 0x000001 after release gives 23 '0' bits (20/43) followed by one '1' bit (40/23).
